// File: rtl/cmac_ctrl_pkg.sv
// cmac_gpio_ctrl shared types and constants.
// State encodings, GPIO command indices, status field offsets.
package cmac_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST        = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_WAIT_ALIGN = 3'd2,
    ST_READY      = 3'd3,
    ST_RESTART    = 3'd4
  } state_t;

  localparam int CMD_LOOPBACK = 0;
  localparam int CMD_SEND     = 1;
  localparam int CMD_RST      = 2;
  localparam int CMD_RESTART  = 3;
  localparam int CMD_CLR      = 4;
  localparam int CMD_W        = 5;

  localparam int STS_LOCK       = 0;
  localparam int STS_ALIGNED    = 1;
  localparam int STS_TX_DONE    = 2;
  localparam int STS_RX_DONE    = 3;
  localparam int STS_DATA_FAIL  = 4;
  localparam int STS_TX_BUSY    = 5;
  localparam int STS_RX_BUSY    = 6;
  localparam int STS_ALIGN_LOST = 7;
  localparam int STS_FAIL       = 8;
  localparam int STS_STATE      = 9;
  localparam int STS_RETRY      = 12;

  localparam logic [3:0] RETRY_MAX = 4'd15;

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cmac_gpio_ctrl_bit_sync.sv
// Multi-stage level synchronizer for host command bits.
// All stages clear on the synchronous reset.
module bit_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sync [STAGES];

  // shift the asynchronous level through the flop chain
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++)
        r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++)
        r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/cmac_gpio_ctrl.sv
// CMAC-side GPIO control/status endpoint.
// Bring-up sequencing, restart pulses, sticky status.
module cmac_gpio_ctrl
  import cmac_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 64,
  parameter int ALIGN_TIMEOUT = 2**20,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        init_clk,
  input  logic        sys_reset,
  input  logic [15:0] gpio_cmd,
  output logic [15:0] gpio_sts,
  input  logic        rx_gt_locked,
  input  logic        rx_aligned,
  input  logic        tx_done,
  input  logic        rx_done,
  input  logic        rx_data_fail,
  input  logic        tx_busy,
  input  logic        rx_busy,
  output logic        loopback_en,
  output logic        send_continuous_pkts,
  output logic        cmac_sys_reset,
  output logic        lbus_tx_rx_restart
);

  localparam int CNT_MAX =
    max_int(RST_CYCLES, ALIGN_TIMEOUT);
  localparam int CW =
    (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] RST_LAST =
    CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] ALIGN_LAST =
    CW'(ALIGN_TIMEOUT - 1);

  logic [CMD_W-1:0] w_cmd_s;
  logic             w_unused_cmd;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_host_rst;
  logic             w_timeout;
  logic             w_align_drop;

  logic             r_restart_q;
  logic             r_restart_rise;
  logic             r_clr_q;
  logic             r_clr_rise;
  logic             r_fail_sticky;
  logic             r_align_lost;
  logic [3:0]       r_retry;

  logic             r_cmac_rst;
  logic             r_lbus;
  logic             r_send;
  logic [15:0]      r_sts;
  logic [15:0]      w_sts;

  assign w_unused_cmd = ^gpio_cmd[15:CMD_W];

  bit_sync #(
    .W      (CMD_W),
    .STAGES (SYNC_STAGES)
  ) u_cmd_sync (
    .i_clk (init_clk),
    .i_rst (sys_reset),
    .i_d   (gpio_cmd[CMD_W-1:0]),
    .o_q   (w_cmd_s)
  );

  // next state; host reset overrides every transition
  always_comb begin
    w_state_nxt  = r_state;
    w_timeout    = 1'b0;
    w_align_drop = 1'b0;
    w_host_rst   = w_cmd_s[CMD_RST];
    if (w_host_rst) begin
      w_state_nxt = ST_RST;
    end else begin
      case (r_state)
        ST_RST: begin
          if (r_cnt == RST_LAST)
            w_state_nxt = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (rx_gt_locked)
            w_state_nxt = ST_WAIT_ALIGN;
        end
        ST_WAIT_ALIGN: begin
          if (rx_aligned) begin
            w_state_nxt = ST_READY;
          end else if (r_cnt == ALIGN_LAST) begin
            w_state_nxt = ST_RST;
            w_timeout   = 1'b1;
          end
        end
        ST_READY: begin
          if (!rx_aligned) begin
            w_state_nxt  = ST_WAIT_ALIGN;
            w_align_drop = 1'b1;
          end else if (r_restart_rise) begin
            w_state_nxt = ST_RESTART;
          end
        end
        ST_RESTART: w_state_nxt = ST_READY;
        default:    w_state_nxt = ST_RST;
      endcase
    end
  end

  // shared counter: cleared on entry, runs in RST/WAIT_ALIGN
  always_comb begin
    w_cnt_nxt = '0;
    if (!w_host_rst && (w_state_nxt == r_state) &&
        (r_state == ST_RST ||
         r_state == ST_WAIT_ALIGN))
      w_cnt_nxt = r_cnt + 1'b1;
  end

  // state register and outputs decoded from next state
  always_ff @(posedge init_clk) begin
    if (sys_reset) begin
      r_state    <= ST_RST;
      r_cnt      <= '0;
      r_cmac_rst <= 1'b1;
      r_lbus     <= 1'b0;
      r_send     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cmac_rst <= (w_state_nxt == ST_RST);
      r_lbus     <= (w_state_nxt == ST_RESTART);
      r_send     <= w_cmd_s[CMD_SEND] &
                    (w_state_nxt == ST_READY);
    end
  end

  // registered rise detect on restart/clear commands
  always_ff @(posedge init_clk) begin
    if (sys_reset) begin
      r_restart_q    <= 1'b0;
      r_restart_rise <= 1'b0;
      r_clr_q        <= 1'b0;
      r_clr_rise     <= 1'b0;
    end else begin
      r_restart_q    <= w_cmd_s[CMD_RESTART];
      r_restart_rise <= w_cmd_s[CMD_RESTART] &
                        ~r_restart_q;
      r_clr_q        <= w_cmd_s[CMD_CLR];
      r_clr_rise     <= w_cmd_s[CMD_CLR] & ~r_clr_q;
    end
  end

  // sticky status and retry count; set beats clear
  always_ff @(posedge init_clk) begin
    if (sys_reset) begin
      r_fail_sticky <= 1'b0;
      r_align_lost  <= 1'b0;
      r_retry       <= '0;
    end else begin
      if (rx_data_fail)
        r_fail_sticky <= 1'b1;
      else if (r_clr_rise)
        r_fail_sticky <= 1'b0;

      if (w_align_drop)
        r_align_lost <= 1'b1;
      else if (r_clr_rise)
        r_align_lost <= 1'b0;

      if (w_timeout) begin
        if (r_retry != RETRY_MAX)
          r_retry <= r_retry + 1'b1;
      end else if (r_clr_rise) begin
        r_retry <= '0;
      end
    end
  end

  // pack the host-visible status word
  always_comb begin
    w_sts                   = '0;
    w_sts[STS_LOCK]         = rx_gt_locked;
    w_sts[STS_ALIGNED]      = rx_aligned;
    w_sts[STS_TX_DONE]      = tx_done;
    w_sts[STS_RX_DONE]      = rx_done;
    w_sts[STS_DATA_FAIL]    = rx_data_fail;
    w_sts[STS_TX_BUSY]      = tx_busy;
    w_sts[STS_RX_BUSY]      = rx_busy;
    w_sts[STS_ALIGN_LOST]   = r_align_lost;
    w_sts[STS_FAIL]         = r_fail_sticky;
    w_sts[STS_STATE +: 3]   = r_state;
    w_sts[STS_RETRY +: 4]   = r_retry;
  end

  // one-cycle registered status
  always_ff @(posedge init_clk) begin
    if (sys_reset)
      r_sts <= '0;
    else
      r_sts <= w_sts;
  end

  assign gpio_sts             = r_sts;
  assign loopback_en          = w_cmd_s[CMD_LOOPBACK];
  assign send_continuous_pkts = r_send;
  assign cmac_sys_reset       = r_cmac_rst;
  assign lbus_tx_rx_restart   = r_lbus;

endmodule
